sram_word_bridge: RTL and testbench
===================================

SRAM_WORD_BRIDGE -- requirements
Module: sram_word_bridge

Interface
REQ-001 Parameter ADR_W, 17, byte-address width of the byte-wide SRAM controller port.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_valid  in  1  CPU word request; held high until mem_ready is seen.
REQ-005 mem_addr  in  32  CPU byte address; bits [ADR_W-1:2] used; [1:0] and upper bits ignored.
REQ-006 mem_wdata  in  32  write data, little-endian lanes (lane i = bits 8i+7:8i).
REQ-007 mem_wstrb  in  4  byte write enables; 4'b0000 means read.
REQ-008 mem_ready  out  1  one-cycle completion pulse.
REQ-009 mem_rdata  out  32  read data, valid while mem_ready=1.
REQ-010 go  out  1  one-cycle start pulse to the byte SRAM controller.
REQ-011 wr  out  1  access direction to controller, 1 = write; valid with go.
REQ-012 adr  out  ADR_W  byte address to controller; valid with go.
REQ-013 dat  out  8  write byte to controller; valid with go.
REQ-014 busy  in  1  controller busy; rises the cycle after an accepted go, falls at completion.
REQ-015 rdt  in  8  controller read byte; valid on first cycle busy=0 after a read.

Function
REQ-016 Bridge SHALL split each 32-bit request into up to four sequential byte accesses, lanes 0..3 in ascending order.
REQ-017 States: IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE.
REQ-018 IDLE: on mem_valid=1, latch addr/wdata/wstrb, lane:=0, go to ISSUE.
REQ-019 ISSUE: read, or wstrb[lane]=1 -> go=1 for one cycle with adr={mem_addr[ADR_W-1:2],lane}, wr=(wstrb!=0), dat=wdata lane, go to WAIT_HI; write with wstrb[lane]=0 -> skip lane, no go issued.
REQ-020 Skipped lane: lane==3 -> DONE, else lane+1 and remain in ISSUE; one cycle per skipped lane.
REQ-021 WAIT_HI: wait for busy=1, then WAIT_LO; go SHALL NOT be reasserted.
REQ-022 WAIT_LO: on busy=0 -> on read, capture rdt into mem_rdata lane; lane==3 -> DONE, else lane+1 and ISSUE.
REQ-023 DONE: mem_ready=1 for exactly one cycle, then IDLE.
REQ-024 go SHALL be issued only when busy=0.
REQ-025 Requester drops mem_valid in the cycle after mem_ready; bridge SHALL NOT start a new request from DONE.
REQ-026 Lanes not read SHALL hold 8'h00 in mem_rdata at read completion; mem_rdata cleared on each new read accept.
REQ-027 Read latency = 4 x (controller access cycles + 2) + 2 clocks from mem_valid to mem_ready.
REQ-028 wstrb=4'b0000 SHALL be a read, all four lanes.
REQ-029 Changes to mem_addr/mem_wdata/mem_wstrb after accept SHALL be ignored until next IDLE.

Reset
REQ-030 rst=1 at a clock edge: state:=IDLE, lane:=0, go=0, wr=0, adr=0, dat=0, mem_ready=0, mem_rdata=0.
REQ-031 Reset mid-transaction SHALL abort immediately with no further go; controller's in-flight byte completes unobserved.
REQ-032 mem_valid held high through reset release SHALL start a fresh request on the first cycle after release.

Structure
REQ-033 Single module, no sub-modules; state encoding localparams local to module.
REQ-034 ADR_W default and lane count shared with the SRAM controller via a common include of memory-map constants.

Verification
REQ-035 Read, addr 0x00000104, controller model returns 11,22,33,44 at bytes 0x104..0x107 -> adr sequence 0x104..0x107, wr=0, mem_rdata=0x44332211, one mem_ready pulse.
REQ-036 Write, addr 0x00000200, wdata 0xDEADBEEF, wstrb 1111 -> four go pulses, dat EF,BE,AD,DE at 0x200..0x203, wr=1.
REQ-037 Write, wstrb 0101, wdata 0xAABBCCDD -> exactly two go pulses: adr 0x200 dat DD, adr 0x202 dat BB.
REQ-038 Controller busy held 6 cycles per access -> go never reasserted while busy=1; mem_ready once after fourth busy fall.
REQ-039 rst asserted during lane 2 of a read -> go/mem_ready stay 0, outputs zero next cycle; subsequent read completes correctly.
REQ-040 Back-to-back requests, mem_valid dropped after mem_ready and reasserted next cycle -> second request's first go no earlier than cycle after IDLE entry.

Source files
------------

// File: rtl/sram_word_bridge_pkg.sv
// sram_word_bridge_pkg
//   Memory-map constants shared between the word bridge and the byte-wide
//   SRAM controller, plus a byte-lane extraction helper.
package sram_word_bridge_pkg;

  // Byte-address width of the SRAM controller port.
  localparam int SRAM_ADR_W = 17;

  // Byte lanes per CPU word and the width of a lane index.
  localparam int NUM_LANES  = 4;
  localparam int LANE_IDX_W = $clog2(NUM_LANES);

  // Little-endian lane select: lane i is bits 8i+7:8i.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [LANE_IDX_W-1:0] lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sram_word_bridge.sv
// sram_word_bridge
//   Splits 32-bit CPU word requests into up to four sequential byte accesses
//   on a byte-wide SRAM controller, lanes 0..3 in ascending order. Write
//   lanes with a clear strobe are skipped; a zero strobe is a full-word read.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb   CPU request (held until mem_ready)
//   mem_ready, mem_rdata         one-cycle completion pulse and read word
//   go, wr, adr, dat             one-cycle access start to the controller
//   busy, rdt                    controller status and read byte
module sram_word_bridge
  import sram_word_bridge_pkg::*;
#(
  parameter int ADR_W = SRAM_ADR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic             go,
  output logic             wr,
  output logic [ADR_W-1:0] adr,
  output logic [7:0]       dat,
  input  logic             busy,
  input  logic [7:0]       rdt
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);

  state_t                  state;
  logic [LANE_IDX_W-1:0]   lane;
  logic [ADR_W-3:0]        word_adr;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;

  logic is_read;
  logic need_access;

  assign is_read     = (wstrb_q == 4'b0000);
  assign need_access = is_read | wstrb_q[lane];

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADR_W], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lane      <= '0;
      word_adr  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      go        <= 1'b0;
      wr        <= 1'b0;
      adr       <= '0;
      dat       <= '0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      go        <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            word_adr <= mem_addr[ADR_W-1:2];
            wdata_q  <= mem_wdata;
            wstrb_q  <= mem_wstrb;
            lane     <= '0;
            // Unread lanes must come back as zero.
            if (mem_wstrb == 4'b0000) mem_rdata <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (need_access) begin
            // Hold off while a previous (possibly orphaned) access finishes.
            if (!busy) begin
              go    <= 1'b1;
              wr    <= !is_read;
              adr   <= {word_adr, lane};
              dat   <= lane_byte(wdata_q, lane);
              state <= WAIT_HI;
            end
          end else if (lane == LAST_LANE) begin
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            lane <= lane + 1'b1;
          end
        end
        WAIT_HI: begin
          if (busy) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!busy) begin
            if (is_read) mem_rdata[{lane, 3'b000} +: 8] <= rdt;
            if (lane == LAST_LANE) begin
              mem_ready <= 1'b1;
              state     <= DONE;
            end else begin
              lane  <= lane + 1'b1;
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          // Always return to IDLE; the requester drops mem_valid now.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_word_bridge.sv
module tb_sram_word_bridge;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic          go;
  logic          wr;
  logic [AW-1:0] adr;
  logic [7:0]    dat;
  logic          busy = 1'b0;
  logic [7:0]    rdt = '0;

  sram_word_bridge #(.ADR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .go(go), .wr(wr), .adr(adr), .dat(dat), .busy(busy), .rdt(rdt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Byte SRAM controller model: busy for acc_cyc cycles per accepted go.
  logic [7:0]    mem [0:1023];
  int            acc_cyc = 2;
  int            cnt = 0;
  logic [AW-1:0] cur_adr = '0;
  logic          cur_wr = 1'b0;
  logic [7:0]    cur_dat = '0;
  always @(posedge clk) begin
    if (!busy && go) begin
      busy    <= 1'b1;
      cnt     <= acc_cyc;
      cur_adr <= adr;
      cur_wr  <= wr;
      cur_dat <= dat;
    end else if (busy) begin
      if (cnt <= 1) begin
        busy <= 1'b0;
        if (cur_wr) mem[cur_adr[9:0]] <= cur_dat;
        else        rdt <= mem[cur_adr[9:0]];
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  // Monitor of controller-side pulses.
  logic [AW-1:0] q_adr[$];
  logic [7:0]    q_dat[$];
  logic          q_wr[$];
  int            q_cyc[$];
  int            ready_cnt = 0;
  int            ready_cyc = 0;
  int            go_busy_err = 0;
  int            go_dbl_err = 0;
  logic          go_prev = 1'b0;
  always @(negedge clk) begin
    if (go) begin
      q_adr.push_back(adr);
      q_dat.push_back(dat);
      q_wr.push_back(wr);
      q_cyc.push_back(cyc);
      if (busy) go_busy_err++;
      if (go_prev) go_dbl_err++;
    end
    go_prev = go;
    if (mem_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    q_adr.delete(); q_dat.delete(); q_wr.delete(); q_cyc.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!mem_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!mem_ready) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One full CPU request; inputs are scrambled right after acceptance.
  task automatic run_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] rd);
    clear_log();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    @(negedge clk);
    mem_addr = 32'hFFFF_FFF0; mem_wdata = 32'h5A5A_5A5A; mem_wstrb = ~ws;
    wait_ready(tag);
    rd = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  logic [31:0] rd;
  int exp_ready = 0;
  int prev_ready_cyc;
  int n;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h104] = 8'h11; mem[10'h105] = 8'h22; mem[10'h106] = 8'h33; mem[10'h107] = 8'h44;
    mem[10'h300] = 8'h01; mem[10'h301] = 8'h02; mem[10'h302] = 8'h03; mem[10'h303] = 8'h04;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_adr", {15'd0, adr}, 32'd0);
    chk("rst_dat", {24'd0, dat}, 32'd0);
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    // Full-word read
    acc_cyc = 2;
    run_req("rd104", 32'h0000_0104, 32'h0, 4'b0000, rd); exp_ready++;
    chk("rd104_data", rd, 32'h4433_2211);
    chk("rd104_ngo", q_adr.size(), 32'd4);
    for (int i = 0; i < 4 && i < q_adr.size(); i++) begin
      chk($sformatf("rd104_adr%0d", i), {15'd0, q_adr[i]}, 32'h104 + i);
      chk($sformatf("rd104_wr%0d", i), {31'd0, q_wr[i]}, 32'd0);
    end

    // Full-word write
    run_req("wr_all", 32'h0000_0200, 32'hDEAD_BEEF, 4'b1111, rd); exp_ready++;
    chk("wr_all_ngo", q_adr.size(), 32'd4);
    for (int i = 0; i < 4 && i < q_adr.size(); i++) begin
      chk($sformatf("wr_all_adr%0d", i), {15'd0, q_adr[i]}, 32'h200 + i);
      chk($sformatf("wr_all_wr%0d", i), {31'd0, q_wr[i]}, 32'd1);
    end
    if (q_dat.size() == 4) begin
      chk("wr_all_dat", {q_dat[3], q_dat[2], q_dat[1], q_dat[0]}, 32'hDEAD_BEEF);
    end

    // Sparse write, lanes 0 and 2 only
    run_req("wr_0101", 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, rd); exp_ready++;
    chk("wr_0101_ngo", q_adr.size(), 32'd2);
    if (q_adr.size() == 2) begin
      chk("wr_0101_adr0", {15'd0, q_adr[0]}, 32'h200);
      chk("wr_0101_dat0", {24'd0, q_dat[0]}, 32'hDD);
      chk("wr_0101_adr1", {15'd0, q_adr[1]}, 32'h202);
      chk("wr_0101_dat1", {24'd0, q_dat[1]}, 32'hBB);
    end

    // Read back merged word, then back-to-back read with a slow controller
    run_req("rd200", 32'h0000_0200, 32'h0, 4'b0000, rd); exp_ready++;
    chk("rd200_data", rd, 32'hDEBB_BEDD);
    prev_ready_cyc = ready_cyc;
    acc_cyc = 6;
    run_req("b2b", 32'h0000_0104, 32'h0, 4'b0000, rd); exp_ready++;
    chk("b2b_data", rd, 32'h4433_2211);
    chk("b2b_ngo", q_adr.size(), 32'd4);
    if (q_cyc.size() > 0) chk("b2b_first_go_late", {31'd0, q_cyc[0] >= prev_ready_cyc + 3}, 32'd1);

    // Only the top lane written, then a read that must zero-fill
    acc_cyc = 1;
    run_req("wr_1000", 32'h0000_0204, 32'h9900_0000, 4'b1000, rd); exp_ready++;
    chk("wr_1000_ngo", q_adr.size(), 32'd1);
    if (q_adr.size() == 1) begin
      chk("wr_1000_adr", {15'd0, q_adr[0]}, 32'h207);
      chk("wr_1000_dat", {24'd0, q_dat[0]}, 32'h99);
    end
    run_req("rd204", 32'h0001_0204, 32'h0, 4'b0000, rd); exp_ready++;
    chk("rd204_data", rd, 32'h9900_0000);

    // Reset during lane 2 of a read
    acc_cyc = 6;
    clear_log();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0000_0104; mem_wstrb = 4'b0000;
    n = 0;
    while (q_adr.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_lane2", q_adr.size(), 32'd3);
    rst = 1'b1; mem_addr = 32'h0000_0300;
    @(negedge clk);
    chk("abort_go", {31'd0, go}, 32'd0);
    chk("abort_ready", {31'd0, mem_ready}, 32'd0);
    chk("abort_adr", {15'd0, adr}, 32'd0);
    chk("abort_dat", {24'd0, dat}, 32'd0);
    chk("abort_rdata", mem_rdata, 32'd0);
    clear_log();
    rst = 1'b0;
    wait_ready("after_abort");
    rd = mem_rdata; exp_ready++;
    @(negedge clk);
    mem_valid = 1'b0;
    chk("after_abort_data", rd, 32'h0403_0201);
    chk("after_abort_ngo", q_adr.size(), 32'd4);
    if (q_adr.size() > 0) chk("after_abort_adr0", {15'd0, q_adr[0]}, 32'h300);

    repeat (10) @(negedge clk);
    chk("ready_pulses", ready_cnt, exp_ready);
    chk("go_while_busy", go_busy_err, 32'd0);
    chk("go_multi_cycle", go_dbl_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
